// File: rtl/key_debounce.sv
// Debounces and edge-detects N push-buttons sampled on the 20 ms enable pulse.
// Outputs: clean level, one-cycle press/release pulses, and the code of the lowest pressed key.
module key_debounce #(
  parameter int N_KEYS         = 4,
  parameter int STABLE_SAMPLES = 2,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic              clk_1ms,
  input  logic              reset,
  input  logic              en_20ms,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              key_valid,
  output logic [2:0]        key_code
);

  localparam int                CNT_W    = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(STABLE_SAMPLES);
  localparam logic [N_KEYS-1:0] PIN_IDLE = {N_KEYS{ACTIVE_LOW}};

  typedef enum logic [1:0] {REL, PPEND, PRS, RPEND} state_t;

  state_t           state     [N_KEYS];
  state_t           state_nxt [N_KEYS];
  logic [CNT_W-1:0] cnt       [N_KEYS];
  logic [CNT_W-1:0] cnt_nxt   [N_KEYS];

  logic [N_KEYS-1:0] sync_q1, sync_q2, s;
  logic [N_KEYS-1:0] press_nxt, release_nxt;
  logic [2:0]        code_nxt;

  assign s         = ACTIVE_LOW ? ~sync_q2 : sync_q2;
  assign key_valid = |key_press;

  always_comb begin
    press_nxt   = '0;
    release_nxt = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      if (en_20ms) begin
        case (state[i])
          REL: if (s[i]) begin
            if (STABLE_SAMPLES == 1) begin
              state_nxt[i] = PRS;
              press_nxt[i] = 1'b1;
            end else begin
              state_nxt[i] = PPEND;
              cnt_nxt[i]   = CNT_ONE;
            end
          end
          PPEND: if (!s[i]) begin
            state_nxt[i] = REL;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] + CNT_ONE == CNT_DONE) begin
            state_nxt[i] = PRS;
            cnt_nxt[i]   = '0;
            press_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
          PRS: if (!s[i]) begin
            if (STABLE_SAMPLES == 1) begin
              state_nxt[i]   = REL;
              release_nxt[i] = 1'b1;
            end else begin
              state_nxt[i] = RPEND;
              cnt_nxt[i]   = CNT_ONE;
            end
          end
          RPEND: if (s[i]) begin
            state_nxt[i] = PRS;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] + CNT_ONE == CNT_DONE) begin
            state_nxt[i]   = REL;
            cnt_nxt[i]     = '0;
            release_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
          default: begin
            state_nxt[i] = REL;
            cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
    // Scan downward so the lowest pressed index wins.
    code_nxt = key_code;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (press_nxt[i]) code_nxt = 3'(i);
    end
  end

  always_comb begin
    key_level = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      key_level[i] = (state[i] == PRS) || (state[i] == RPEND);
    end
  end

  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      sync_q1     <= PIN_IDLE;
      sync_q2     <= PIN_IDLE;
      key_press   <= '0;
      key_release <= '0;
      key_code    <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        state[i] <= REL;
        cnt[i]   <= '0;
      end
    end else begin
      sync_q1     <= key_in;
      sync_q2     <= sync_q1;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_code    <= code_nxt;
      for (int i = 0; i < N_KEYS; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table, reset/enable corner sequences, and a random run against a run-length model.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int SS = 2;

  logic          clk_1ms = 1'b0;
  logic          reset;
  logic          en_20ms;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level, key_press, key_release;
  logic          key_valid;
  logic [2:0]    key_code;

  key_debounce #(.N_KEYS(NK), .STABLE_SAMPLES(SS), .ACTIVE_LOW(1'b1)) dut (
    .clk_1ms    (clk_1ms),
    .reset      (reset),
    .en_20ms    (en_20ms),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_valid  (key_valid),
    .key_code   (key_code)
  );

  always #5 clk_1ms = ~clk_1ms;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] obs;
  assign obs = {key_level, key_press, key_release, key_valid, key_code};

  function automatic logic [15:0] pack(input logic [3:0] lvl, input logic [3:0] prs,
                                       input logic [3:0] rel, input logic vld, input logic [2:0] code);
    return {lvl, prs, rel, vld, code};
  endfunction

  task automatic chk(input string nm, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got lvl=%b prs=%b rel=%b vld=%b code=%0d, want lvl=%b prs=%b rel=%b vld=%b code=%0d",
               nm, obs[15:12], obs[11:8], obs[7:4], obs[3], obs[2:0],
               exp[15:12], exp[11:8], exp[7:4], exp[3], exp[2:0]);
    end
  endtask

  task automatic step();
    @(posedge clk_1ms);
    #1;
  endtask

  // 20 idle cycles then one sample cycle: one en_20ms period of 21 cycles.
  task automatic sample();
    en_20ms = 1'b0;
    repeat (20) step();
    en_20ms = 1'b1;
    step();
    en_20ms = 1'b0;
  endtask

  typedef struct {
    logic [3:0] key;
    logic       en;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic       vld;
    logic [2:0] code;
  } vec_t;

  vec_t tbl [21];

  // Model state for the random phase
  logic [3:0] m_lvl, m_prs, m_rel, p1, p2, s_m;
  logic [2:0] m_code;
  int         run [NK];

  initial begin
    // Each row is applied before an edge and checked after it; en_20ms high samples every cycle.
    tbl[0]  = '{4'b1101, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0};
    tbl[1]  = '{4'b1101, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0};
    tbl[2]  = '{4'b1101, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0};
    tbl[3]  = '{4'b1101, 1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b1, 3'd1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 3'd1};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 3'd1};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 3'd1};
    tbl[7]  = '{4'b1110, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 3'd1};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd1};
    tbl[9]  = '{4'b1110, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd1};
    tbl[10] = '{4'b0011, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd1};
    tbl[11] = '{4'b0011, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd1};
    tbl[12] = '{4'b0011, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd1};
    tbl[13] = '{4'b0011, 1'b1, 4'b1100, 4'b1100, 4'b0000, 1'b1, 3'd2};
    tbl[14] = '{4'b0011, 1'b1, 4'b1100, 4'b0000, 4'b0000, 1'b0, 3'd2};
    tbl[15] = '{4'b1111, 1'b0, 4'b1100, 4'b0000, 4'b0000, 1'b0, 3'd2};
    tbl[16] = '{4'b0000, 1'b0, 4'b1100, 4'b0000, 4'b0000, 1'b0, 3'd2};
    tbl[17] = '{4'b0011, 1'b1, 4'b1100, 4'b0000, 4'b0000, 1'b0, 3'd2};
    tbl[18] = '{4'b0011, 1'b1, 4'b1100, 4'b0000, 4'b0000, 1'b0, 3'd2};
    tbl[19] = '{4'b0011, 1'b0, 4'b1100, 4'b0000, 4'b0000, 1'b0, 3'd2};
    tbl[20] = '{4'b0011, 1'b1, 4'b1100, 4'b0000, 4'b0000, 1'b0, 3'd2};

    reset   = 1'b1;
    en_20ms = 1'b0;
    key_in  = 4'b1111;
    step();
    step();
    chk("reset_state", 16'h0000);

    @(negedge clk_1ms);
    reset = 1'b0;
    for (int r = 0; r < 21; r++) begin
      key_in  = tbl[r].key;
      en_20ms = tbl[r].en;
      step();
      chk($sformatf("vec%0d", r), pack(tbl[r].lvl, tbl[r].prs, tbl[r].rel, tbl[r].vld, tbl[r].code));
    end

    // Asynchronous reset clears pressed level and held code mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_clear", 16'h0000);
    en_20ms = 1'b0;
    key_in  = 4'b1111;
    step();
    step();
    reset = 1'b0;

    // Reset in the middle of a pending press discards the partial count.
    key_in = 4'b0111;
    repeat (3) step();
    sample();
    chk("pend_first_sample", 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    chk("pend_reset_outputs", 16'h0000);
    step();
    step();
    reset = 1'b0;
    sample();
    chk("post_reset_sample1", 16'h0000);
    sample();
    chk("post_reset_sample2", pack(4'b1000, 4'b1000, 4'b0000, 1'b1, 3'd3));
    step();
    chk("post_press_hold", pack(4'b1000, 4'b0000, 4'b0000, 1'b0, 3'd3));

    // With the enable low, pin activity never reaches the outputs.
    en_20ms = 1'b0;
    for (int c = 0; c < 100; c++) begin
      key_in = 4'($urandom);
      step();
      chk($sformatf("gate%0d", c), pack(4'b1000, 4'b0000, 4'b0000, 1'b0, 3'd3));
    end

    // Random phase against a run-length model of the debounce rules.
    reset   = 1'b1;
    en_20ms = 1'b0;
    key_in  = 4'b1111;
    step();
    step();
    chk("rand_reset", 16'h0000);
    reset  = 1'b0;
    m_lvl  = '0;
    m_prs  = '0;
    m_rel  = '0;
    m_code = '0;
    p1     = 4'b1111;
    p2     = 4'b1111;
    for (int k = 0; k < NK; k++) run[k] = 0;

    for (int c = 0; c < 4000; c++) begin
      if (c < 2000) begin
        en_20ms = (c % 21 == 20);
        for (int k = 0; k < NK; k++) if ($urandom_range(0, 39) == 0) key_in[k] = ~key_in[k];
      end else if (c < 3000) begin
        en_20ms = 1'b1;
        for (int k = 0; k < NK; k++) if ($urandom_range(0, 3) == 0) key_in[k] = ~key_in[k];
      end else begin
        en_20ms = ($urandom_range(0, 2) == 0);
        for (int k = 0; k < NK; k++) if ($urandom_range(0, 7) == 0) key_in[k] = ~key_in[k];
      end
      @(posedge clk_1ms);
      // A level change is accepted after SS consecutive samples that differ from it.
      s_m   = ~p2;
      m_prs = '0;
      m_rel = '0;
      if (en_20ms) begin
        for (int k = 0; k < NK; k++) begin
          if (s_m[k] != m_lvl[k]) begin
            run[k]++;
            if (run[k] == SS) begin
              if (m_lvl[k]) m_rel[k] = 1'b1;
              else          m_prs[k] = 1'b1;
              m_lvl[k] = ~m_lvl[k];
              run[k]   = 0;
            end
          end else begin
            run[k] = 0;
          end
        end
      end
      for (int k = NK - 1; k >= 0; k--) if (m_prs[k]) m_code = 3'(k);
      p2 = p1;
      p1 = key_in;
      #1;
      chk($sformatf("rand%0d", c), pack(m_lvl, m_prs, m_rel, |m_prs, m_code));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces and edge-detects up to N mechanical push-buttons using the periodic 20 ms sample pulse produced by the 20 ms tick divider. It sits directly downstream of that divider and upstream of the control FSMs. It delivers three outputs per key: a clean level, one-cycle press/release pulses, and an encoded "key hit" code for the lowest-index key pressed.

## Interface
- N_KEYS, 4: number of independent keys; 1..8.
- STABLE_SAMPLES, 2: consecutive identical samples required to accept a level change; 1..15.
- ACTIVE_LOW, 1: 1 = pin low means pressed; 0 = pin high means pressed.
- clk_1ms  in  1  block clock (1 ms period); the only clock.
- reset  in  1  asynchronous, active-high reset.
- en_20ms  in  1  sample enable; the 20 ms divider pulse, one clk_1ms cycle wide.
- key_in  in  N_KEYS  raw button pins, asynchronous to clk_1ms.
- key_level  out  N_KEYS  debounced level, 1 = pressed.
- key_press  out  N_KEYS  one-cycle pulse per accepted press.
- key_release  out  N_KEYS  one-cycle pulse per accepted release.
- key_valid  out  1  one-cycle pulse when any bit of key_press is set.
- key_code  out  3  index of the lowest key in key_press; holds its value between pulses.

## Operation
- Synchronizer:
  - Each key_in bit passes through two clk_1ms flops.
  - The result is normalized to s[i] (1 = pressed) according to ACTIVE_LOW.
- Per-key FSM, 4 states, plus a counter cnt sized to hold STABLE_SAMPLES.
- The FSM advances only in cycles where en_20ms = 1. In all other cycles, state and cnt hold.
  - REL (released):
    - s=1: go to PPEND with cnt=1.
    - s=0: stay.
  - PPEND:
    - s=1: cnt+1. When cnt+1 == STABLE_SAMPLES, go to PRS and fire press.
    - s=0: return to REL with cnt=0.
  - PRS (pressed):
    - s=0: go to RPEND with cnt=1.
    - s=1: stay.
  - RPEND:
    - s=0: cnt+1. When cnt+1 == STABLE_SAMPLES, go to REL and fire release.
    - s=1: return to PRS with cnt=0.
  - STABLE_SAMPLES = 1: REL→PRS and PRS→REL happen directly on the first differing sample; the pending states are skipped.
- key_level[i] = 1 in PRS and RPEND; 0 in REL and PPEND.
- key_press[i] and key_release[i] are registered. Each is high for exactly the one cycle after the en_20ms cycle that completed the count.
- key_valid = OR of the registered key_press bits, in the same cycle.
- key_code:
  - Loaded with the lowest set index of the press vector in the same register update.
  - Unchanged when no press fires.
  - Zero-extended for N_KEYS < 8.
- Keys are fully independent; simultaneous completions on several keys each pulse in the same cycle.
- en_20ms held high continuously is legal: every cycle is then a sample.

## Timing
- Reset (asynchronous assert; released synchronously by the surrounding design):
  - All FSMs go to REL, all cnt = 0.
  - Synchronizer flops go to the inactive pin level (1 if ACTIVE_LOW, else 0).
  - key_level = 0, key_press = 0, key_release = 0, key_valid = 0, key_code = 0.
- Reset during PPEND or RPEND discards the pending count; no pulse fires for that transition.
- Latency from a pin change:
  - 2 cycles for the synchronizer.
  - Then STABLE_SAMPLES en_20ms cycles in which s equals the new level.
  - Then 1 cycle register delay.
- key_level updates in the same cycle as the corresponding pulse.
- A press and a release never pulse on the same key in the same cycle.
- The minimum accepted press-to-release interval is STABLE_SAMPLES samples.
- With en_20ms low, key_in changes never reach the outputs (only the synchronizer moves).

## Test plan
Configuration for all scenarios: N_KEYS=4, STABLE_SAMPLES=2, ACTIVE_LOW=1. en_20ms pulses every 21 cycles unless stated.
1. Clean press: key_in 4'b1111 → 4'b1101, held.
   - key_press = 4'b0010, key_valid = 1, key_code = 1 for one cycle, right after the 2nd en_20ms that samples the low pin.
   - key_level = 4'b0010 from that cycle on.
2. Bounce rejection: key0 low for exactly one sample window, then high.
   - No key_press, no key_valid; key_level stays 4'b0000.
3. Release: from the pressed state of scenario 1, set key_in = 4'b1111.
   - key_release = 4'b0010 for one cycle after the 2nd high sample.
   - key_level = 0; key_code still reads 1.
4. Simultaneous press: key_in 4'b1111 → 4'b0011.
   - key_press = 4'b1100 in a single cycle, key_valid = 1, key_code = 2.
5. Reset mid-pending: press key3, assert reset after the 1st sample, release reset with the pin still low.
   - All outputs 0 during reset.
   - key_press[3] fires only after 2 further samples taken after reset release.
6. Enable gating: hold en_20ms = 0 and toggle key_in arbitrarily for 100 cycles.
   - All outputs remain at their pre-test values.
